// File: rtl/four_bit_down_timer_if.sv
// four_bit_down_timer_if: control and status bundle between the timer and its controlling logic
interface four_bit_down_timer_if;
    logic       ld;
    logic [3:0] p;
    logic       start;
    logic       stop;
    logic       auto_reload;
    logic [3:0] v;
    logic       busy;
    logic       tc;
    logic       done;
    modport master (output ld, p, start, stop, auto_reload, input v, busy, tc, done);
    modport slave  (input ld, p, start, stop, auto_reload, output v, busy, tc, done);
endinterface

// File: rtl/four_bit_down_timer.sv
// four_bit_down_timer: loadable 4-bit down timer with one-shot and auto-reload modes
module four_bit_down_timer (
    input logic                 ck,
    input logic                 r,
    four_bit_down_timer_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
    logic [1:0] st;
    logic [3:0] rl;
    logic [3:0] cnt;
    // load beats stop beats start beats counting; zero count either reloads or finishes
    always_ff @(posedge ck or negedge r) begin
        if (!r) begin
            st  <= IDLE;
            rl  <= 4'd0;
            cnt <= 4'd0;
        end else if (bus.ld) begin
            rl  <= bus.p;
            cnt <= bus.p;
            st  <= IDLE;
        end else if (st == RUN) begin
            if (bus.stop) st <= IDLE;
            else if (cnt != 4'd0) cnt <= cnt - 4'd1;
            else if (bus.auto_reload) cnt <= rl;
            else st <= DONE;
        end else if (bus.start) begin
            cnt <= rl;
            st  <= RUN;
        end
    end
    // status is decoded purely from registered state
    always_comb begin
        bus.v    = cnt;
        bus.busy = st == RUN;
        bus.tc   = st == RUN && cnt == 4'd0;
        bus.done = st == DONE;
    end
endmodule

// File: doc/four_bit_down_timer.md
# four_bit_down_timer

Loadable 4-bit down-counting timer: the count-down counterpart to the team's 4-bit up/down counter. It counts a programmed preset down to zero and flags terminal count. In auto-reload mode it acts as a periodic tick generator. In one-shot mode it acts as a delay timer with a start/done handshake toward the controlling logic. Its count output uses the same 4-bit, LSB-first `v0..v3` weighting as the up/down counter, so both blocks can share downstream decode.

## Interface
Parameters: none. Width is fixed at 4 bits.

- `ck`  in  1  clock; all state changes on the rising edge
- `r`  in  1  reset, asynchronous, active-low; `r=0` forces reset state immediately
- `ld`  in  1  load strobe: `rl <= p`, `v <= p`, go to IDLE
- `p`  in  4  preset value (`p[0]` = LSB)
- `start`  in  1  start request; sampled in IDLE and DONE only
- `stop`  in  1  abort request; sampled in RUN only
- `auto`  in  1  0 = one-shot, 1 = auto-reload; sampled at the cycle `v==0` in RUN
- `v`  out  4  current count (`v[0]` = LSB)
- `busy`  out  1  high while in RUN
- `tc`  out  1  terminal count: high while in RUN and `v==0`
- `done`  out  1  high while in DONE

## Operation
Internal state: 4-bit reload register `rl`, 4-bit count `v`, and a 3-state FSM (IDLE, RUN, DONE).

Reset (`r=0`, asynchronous):
- FSM to IDLE; `rl=0`, `v=0`.
- `busy=0`, `tc=0`, `done=0`.
- All outputs remain at these values until the first edge after `r` returns high.

Per-edge priority, highest first: `ld` > `stop` > `start` > counting.

- **ld=1 (any state):** `rl<=p`, `v<=p`, FSM to IDLE. `start`, `stop` and counting are ignored that cycle.
- **IDLE:**
  - `start=1`: `v<=rl`, go to RUN.
  - Otherwise hold `v`.
- **RUN:**
  - `stop=1`: go to IDLE, `v` holds its current value. There is no resume; the next `start` reloads from `rl`.
  - `v!=0`: `v<=v-1`.
  - `v==0` and `auto=1`: `v<=rl`, stay in RUN.
  - `v==0` and `auto=0`: go to DONE, `v` holds 0.
  - `start` is ignored in RUN.
- **DONE:**
  - `start=1`: `v<=rl`, go to RUN.
  - Otherwise hold (`v=0`, `done=1`).
  - `stop` is ignored in DONE.
- **Decrement:** modulo 16, but wrap from 0 to 15 can never occur, because `v==0` always takes the reload or DONE path.
- **`rl=0` with start:** RUN is entered with `v=0`, so `tc` is high in the first RUN cycle.
  - One-shot: DONE on the next edge.
  - Auto-reload: stays in RUN with `v=0`, and `tc` is held high continuously.
- **`auto` changes mid-run:** only its value in the `v==0` cycle matters.

## Timing
- All outputs are decoded from registered state. They have no combinational path from any input.
- **Start latency:** `start` sampled at edge k → `busy=1` and `v=rl` after edge k.
- **One-shot with `rl=N`:**
  - `v` sequence in RUN: N, N−1, …, 0, giving N+1 cycles with `busy=1`.
  - `tc=1` for exactly the last of those cycles.
  - `done=1` from the following edge.
- **Auto-reload with `rl=N`:** `tc` pulses one cycle every N+1 cycles; `busy` stays 1.
- **`stop` at edge k:** `busy=0` after edge k. If `v==0` at that edge, `tc` drops and DONE is not entered.
- **`ld` during RUN:** takes effect at that edge. `busy=0` and `v=p` after the edge, and `rl` is updated.
- **Reset mid-RUN:** outputs go to their reset values asynchronously; `rl` is lost, and `ld` is required before a nonzero run.

## Test plan
- **Reset:** assert `r=0` mid-RUN with `v=7`, between clock edges → `v=0`, `busy=tc=done=0` immediately. After release, `start` runs with `rl=0` → `tc` high one cycle, then `done=1`.
- **One-shot:** `ld` with `p=5`, then `start`, `auto=0` → `v` = 5,4,3,2,1,0 over 6 cycles with `busy=1`, `tc=1` only at `v=0`. Then `done=1`, `v=0` holds for 10 idle cycles. A second `start` repeats the sequence.
- **Auto-reload:** `ld` with `p=3`, `start`, `auto=1` → `v` = 3,2,1,0,3,2,1,0…, `tc` high every 4th cycle, `busy` constant 1. Drop `auto` during `v=2` → DONE after the next `v=0`.
- **Stop:** `p=9`, `start`, `stop` at `v=4` → IDLE, `v=4` held, `busy=0`, `done=0`. Then `start` → `v=9` (reload, not resume).
- **Priority:** in RUN at `v=6`, assert `ld` (`p=2`), `stop` and `start` on the same edge → IDLE with `v=2`, `rl=2`. `start` asserted in RUN alone is ignored: the count continues with no reload.
- **Boundary values:**
  - `p=15`, one-shot → 16 RUN cycles, `v` 15 down to 0, no wrap.
  - `p=0`, `auto=1` → `tc` stuck at 1, `v=0`, `busy=1` until `stop`.
